// File: rtl/regfile_wb_sched.sv
// Shares the regfile write port among writeback sources, registers the winning write and tracks outstanding long-latency writes.
// Optional starvation guard: define REGFILE_WB_SCHED_STARVE_GUARD_EN.
module regfile_wb_sched #(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int num_req_p         = 3,
    parameter int num_rs_p          = 2,
    parameter int x0_tied_to_zero_p = 1,
    parameter int max_wait_p        = 16,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p-1:0][addr_width_lp-1:0]  req_addr_i,
    input  logic [num_req_p-1:0][width_p-1:0]        req_data_i,
    output logic [num_req_p-1:0]                     req_yumi_o,
    output logic                                     w_v_o,
    output logic [addr_width_lp-1:0]                 w_addr_o,
    output logic [width_p-1:0]                       w_data_o,
    input  logic                                     sb_set_v_i,
    input  logic [addr_width_lp-1:0]                 sb_set_addr_i,
    input  logic [num_rs_p-1:0][addr_width_lp-1:0]   sb_check_addr_i,
    output logic [num_rs_p-1:0]                      sb_pending_o,
    output logic                                     stall_o
);
    localparam int ptr_w_lp = $clog2(num_req_p);

    logic [ptr_w_lp-1:0]      rr_ptr_q, rr_ptr_d;
    logic                     w_v_q, w_v_d;
    logic [addr_width_lp-1:0] w_addr_q, w_addr_d;
    logic [width_p-1:0]       w_data_q, w_data_d;
    logic [els_p-1:0]         sb_q, sb_d;

    logic                     hi_found;
    logic [ptr_w_lp-1:0]      hi_win;
    logic                     win_v;
    logic [ptr_w_lp-1:0]      win_idx;
    logic [addr_width_lp-1:0] win_addr;
    logic [width_p-1:0]       win_data;
    logic                     override;
    logic                     wr_drop;
    logic                     set_ok;

    // Round-robin search over the long-latency requesters only, starting at the pointer.
    always_comb begin
        int idx;
        hi_found = 1'b0;
        hi_win   = '0;
        for (int k = 0; k < num_req_p - 1; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= num_req_p) idx = idx - (num_req_p - 1);
            if (!hi_found && req_v_i[idx]) begin
                hi_found = 1'b1;
                hi_win   = ptr_w_lp'(idx);
            end
        end
    end

`ifdef REGFILE_WB_SCHED_STARVE_GUARD_EN
    localparam int cnt_w_lp = $clog2(max_wait_p + 1);
    logic [num_req_p-1:1][cnt_w_lp-1:0] wait_q, wait_d;
    logic starve;

    always_comb begin
        starve = 1'b0;
        for (int i = 1; i < num_req_p; i++) begin
            if (int'(wait_q[i]) >= max_wait_p) starve = 1'b1;
        end
        wait_d = wait_q;
        for (int i = 1; i < num_req_p; i++) begin
            if (win_v && int'(win_idx) == i)
                wait_d[i] = '0;
            else if (req_v_i[i] && int'(wait_q[i]) < max_wait_p)
                wait_d[i] = wait_q[i] + cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) wait_q <= '0;
        else            wait_q <= wait_d;
    end

    assign override = starve & hi_found;
    assign stall_o  = override & req_v_i[0];
`else
    assign override = 1'b0;
    assign stall_o  = 1'b0;
`endif

    always_comb begin
        win_v   = 1'b0;
        win_idx = '0;
        if (req_v_i[0] && !override) begin
            win_v = 1'b1;
        end else if (hi_found) begin
            win_v   = 1'b1;
            win_idx = hi_win;
        end
        req_yumi_o = '0;
        if (win_v) req_yumi_o[win_idx] = 1'b1;
    end

    assign win_addr = req_addr_i[win_idx];
    assign win_data = req_data_i[win_idx];
    assign wr_drop  = (x0_tied_to_zero_p != 0) && (win_addr == '0);
    assign set_ok   = sb_set_v_i && !((x0_tied_to_zero_p != 0) && (sb_set_addr_i == '0));

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_v && win_idx != '0) begin
            if (int'(win_idx) == num_req_p - 1) rr_ptr_d = ptr_w_lp'(1);
            else                                rr_ptr_d = win_idx + ptr_w_lp'(1);
        end

        w_v_d    = win_v & ~wr_drop;
        w_addr_d = w_v_d ? win_addr : w_addr_q;
        w_data_d = w_v_d ? win_data : w_data_q;

        // Clear first so a same-cycle set of the same register wins.
        sb_d = sb_q;
        if (win_v && win_idx != '0) sb_d[win_addr] = 1'b0;
        if (set_ok)                 sb_d[sb_set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= ptr_w_lp'(1);
            w_v_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            sb_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            w_v_q    <= w_v_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            sb_q     <= sb_d;
        end
    end

    always_comb begin
        for (int i = 0; i < num_rs_p; i++) sb_pending_o[i] = sb_q[sb_check_addr_i[i]];
    end

    assign w_v_o    = w_v_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-port scheduler for the core's synthesized register file.
- Shares one regfile write port among several writeback sources:
  - requester 0: execute pipeline
  - requesters 1..N-1: remote-load return, integer divider, and similar long-latency units
- Registers the winning write for one cycle, then drives it to the regfile.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards against outstanding long-latency writes.

Parameters:
- width_p, 32, data width per register
- els_p, 32, number of registers
- num_req_p, 3, writeback requesters (min 2); index 0 is the pipeline
- num_rs_p, 2, scoreboard check ports
- x0_tied_to_zero_p, 1, register 0 is never written or scoreboarded
- max_wait_p, 16, starvation threshold (used only with the optional feature)
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), localparam

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous reset, active-low
- req_v_i  in  num_req_p  writeback request valid
- req_addr_i  in  num_req_p x addr_width_lp  destination register
- req_data_i  in  num_req_p x width_p  write data
- req_yumi_o  out  num_req_p  request consumed this cycle (one-hot or zero)
- w_v_o  out  1  regfile write valid
- w_addr_o  out  addr_width_lp  regfile write address
- w_data_o  out  width_p  regfile write data
- sb_set_v_i  in  1  long-latency op issued; mark destination pending
- sb_set_addr_i  in  addr_width_lp  destination to mark
- sb_check_addr_i  in  num_rs_p x addr_width_lp  source registers to check
- sb_pending_o  out  num_rs_p  source has an outstanding write
- stall_o  out  1  pipeline (requester 0) must hold this cycle

Behaviour:
- Reset (asynchronous, active-low):
  - w_v_o=0, w_addr_o=0, w_data_o=0
  - scoreboard all clear
  - round-robin pointer = 1
  - wait counters = 0
  - stall_o=0
  - An in-flight registered write is dropped; the scoreboard is cleared regardless.
- Arbitration (combinational, same cycle):
  - If req_v_i[0]=1, requester 0 wins.
  - Otherwise the winner is the first valid requester among 1..num_req_p-1, searching from the round-robin pointer upward with wrap.
  - The pointer advances to winner+1, wrapping from num_req_p-1 to 1, only when a requester >=1 wins.
  - req_yumi_o[winner]=1 in the grant cycle; all other bits are 0.
- Write stage:
  - The winner's addr/data are registered at the grant edge.
  - w_v_o=1 exactly one cycle after grant.
  - w_v_o=0 in any cycle following a grant-free cycle.
  - w_addr_o/w_data_o hold their last values when w_v_o=0.
- x0 (x0_tied_to_zero_p=1):
  - A request to address 0 is still granted (yumi=1) but produces w_v_o=0.
  - sb_set with address 0 is ignored.
  - sb_pending_o for address 0 is always 0.
- Scoreboard (els_p bits, registered):
  - Set: sb_set_v_i sets bit[sb_set_addr_i].
  - Clear: a grant to requester >=1 clears bit[req_addr] at the grant edge.
  - Requester-0 grants never clear bits.
  - Set and clear to the same address in the same cycle: set wins, and the bit stays 1.
  - Set of an already-pending bit: no change.
  - sb_pending_o[i] = bit[sb_check_addr_i[i]] from register state, with no same-cycle forwarding. The pipeline reads the regfile only after the write lands.
- stall_o = req_v_i[0] & 0 in base mode, i.e. constant 0. Requester 0 is never blocked.

Optional Feature:
- Macro: REGFILE_WB_SCHED_STARVE_GUARD_EN
- Defined:
  - Each requester >=1 has a saturating wait counter: it increments while valid and not granted, and resets to 0 on grant.
  - When any counter reaches max_wait_p, the round-robin winner among 1..N-1 beats requester 0 for that cycle.
  - In that cycle stall_o=1, req_yumi_o[0]=0, and requester 0 must hold its request.
- Undefined:
  - Strict priority to requester 0.
  - stall_o tied to 0.
  - No counters.

Test Plan:
- Reset mid-write:
  - Stimulus: grant req1 addr 5 data 0xA5, then drop reset_n_i before the next edge.
  - Required response: w_v_o=0 immediately; sb_pending_o for addr 5 reads 0 after release.
- Priority and latency:
  - Stimulus: req0 (addr 3, 0x11) and req2 (addr 4, 0x22) valid together.
  - Required response: yumi=001; next cycle w_v_o=1, addr 3, 0x11. Then yumi=100; next cycle addr 4, 0x22.
- Round robin:
  - Stimulus: req1 and req2 continuously valid, req0 idle.
  - Required response: grants alternate 1,2,1,2; w_v_o=1 every cycle after the first.
- Scoreboard:
  - Stimulus: sb_set addr 7; check addr 7 → pending=1; req1 writes addr 7.
  - Required response: pending=0 the cycle after grant. Set and grant to addr 9 in the same cycle leaves pending=1.
- x0:
  - Stimulus: req1 addr 0 with data 0xFFFF_FFFF; sb_set addr 0.
  - Required response: yumi[1]=1, w_v_o stays 0, sb_pending_o for addr 0 is 0.
- Guard (macro defined, max_wait_p=4):
  - Stimulus: req0 and req1 continuously valid.
  - Required response: req1 granted after 4 waiting cycles with stall_o=1 for that single cycle.
